// File: rtl/fifo_byte_serializer_pkg.sv
// fifo_byte_serializer_pkg: widths and state encoding shared by the FIFO and its byte serializer.
// Revision: 1.0
`default_nettype none

package fifo_byte_serializer_pkg;

    localparam int DATA_W         = 32;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/fifo_byte_serializer.sv
// fifo_byte_serializer: pops 32-bit FIFO words and streams them LSB-first as bytes, flagging frame ends.
// Revision: 1.0
`default_nettype none

module fifo_byte_serializer
    import fifo_byte_serializer_pkg::*;
#(
    parameter int FRAME_WORDS = 4,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       fifo_data,
    input  logic              fifo_empty,
    output logic              fifo_read,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic [CNT_W-1:0]  frame_count
);

    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(FRAME_WORDS - 1);
    localparam logic [1:0]       LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    state_t              state;
    state_t              state_next;
    logic [DATA_W-1:0]   word_q;
    logic [1:0]          byte_idx;
    logic [CNT_W-1:0]    word_idx;
    logic                sending;
    logic                handshake;
    logic                last_hs;

    assign sending   = (state == SEND) & ~reset;
    assign handshake = sending & out_ready;
    assign last_hs   = handshake & (byte_idx == LAST_BYTE);

    // Refill on the final byte's handshake keeps the byte stream gap-free across words.
    assign fifo_read = ~reset & ~fifo_empty & ((state == IDLE) | last_hs);

    assign out_valid = sending;
    assign out_data  = sending ? word_q[{byte_idx, 3'b000} +: BYTE_W] : '0;
    assign out_last  = sending & (byte_idx == LAST_BYTE) & (word_idx == LAST_WORD);
    assign busy      = sending;

    always_comb begin
        state_next = state;
        if (fifo_read) begin
            state_next = SEND;
        end else if (last_hs) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_q   <= '0;
            byte_idx <= '0;
        end else if (fifo_read) begin
            word_q   <= fifo_data;
            byte_idx <= '0;
        end else if (handshake && (byte_idx != LAST_BYTE)) begin
            byte_idx <= byte_idx + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_idx    <= '0;
            frame_count <= '0;
        end else if (last_hs) begin
            if (word_idx == LAST_WORD) begin
                word_idx    <= '0;
                frame_count <= frame_count + 1'b1;
            end else begin
                word_idx <= word_idx + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_byte_serializer.sv
// tb_fifo_byte_serializer: queue-backed FIFO and word-level reference model checking the serializer every cycle.
// Revision: 1.0
`default_nettype none

module tb_fifo_byte_serializer;

    localparam int FW = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] fifo_data = '0;
    logic        fifo_empty = 1'b1;
    logic        out_ready = 1'b1;

    logic        fifo_read, fifo_read1;
    logic [7:0]  out_data, out_data1;
    logic        out_valid, out_valid1, out_last, out_last1, busy, busy1;
    logic [15:0] frame_count, frame_count1;

    always #5 clk = ~clk;

    fifo_byte_serializer #(.FRAME_WORDS(FW), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
        .fifo_read(fifo_read), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy), .frame_count(frame_count)
    );

    fifo_byte_serializer #(.FRAME_WORDS(1), .CNT_W(16)) u_dut_fw1 (
        .clk(clk), .reset(reset), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
        .fifo_read(fifo_read1), .out_data(out_data1), .out_valid(out_valid1),
        .out_ready(out_ready), .out_last(out_last1), .busy(busy1), .frame_count(frame_count1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    // Bench-side FIFO contents and accepted-byte log.
    logic [31:0] fq[$];
    logic [7:0]  log_data[$];
    logic        log_last[$];
    int          pop_cnt = 0;

    function automatic void drive_fifo();
        fifo_empty = (fq.size() == 0);
        fifo_data  = (fq.size() != 0) ? fq[0] : 32'h0;
    endfunction

    task automatic push(input logic [31:0] w);
        fq.push_back(w);
        drive_fifo();
    endtask

    // Word-level model: current word, bytes already sent, total words completed.
    bit          m_busy = 0;
    logic [31:0] m_word = '0;
    int          m_sent = 0;
    int          m_words = 0;

    initial begin : compare
        bit   e_read, e_valid, e_last, e_last1, hs, do_pop, do_clear;
        logic [7:0] e_data;
        @(posedge clk);
        forever begin
            @(negedge clk);
            #2;
            e_valid = !reset && m_busy;
            e_data  = e_valid ? 8'((m_word >> (8 * m_sent)) & 32'hff) : 8'h00;
            e_last  = e_valid && (m_sent == 3) && ((m_words % FW) == FW - 1);
            e_last1 = e_valid && (m_sent == 3);
            e_read  = !reset && (fq.size() != 0) && (!m_busy || (out_ready && m_sent == 3));

            check("fifo_read", fifo_read, e_read);
            check("out_valid", out_valid, e_valid);
            check("out_data", out_data, e_data);
            check("out_last", out_last, e_last);
            check("busy", busy, e_valid);
            check("frame_count", frame_count, 32'((m_words / FW) % 65536));
            check("fw1_fifo_read", fifo_read1, e_read);
            check("fw1_out_data", out_data1, e_data);
            check("fw1_out_last", out_last1, e_last1);
            check("fw1_frame_count", frame_count1, 32'(m_words % 65536));

            if (out_valid && out_ready) begin
                log_data.push_back(out_data);
                log_last.push_back(out_last);
            end
            if (fifo_read) pop_cnt++;

            do_pop = 0;
            do_clear = reset;
            if (reset) begin
                m_busy = 0; m_sent = 0; m_words = 0;
            end else begin
                hs = m_busy && out_ready;
                if (hs && m_sent == 3) m_words++;
                if (e_read) begin
                    m_word = fq[0]; m_sent = 0; m_busy = 1; do_pop = 1;
                end else if (hs) begin
                    if (m_sent == 3) m_busy = 0;
                    else m_sent++;
                end
            end

            @(posedge clk);
            #1;
            if (do_clear) fq.delete();
            else if (do_pop) void'(fq.pop_front());
            drive_fifo();
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        log_data.delete();
        log_last.delete();
        pop_cnt = 0;
    endtask

    initial begin : stimulus
        int nlast;
        logic [31:0] w;
        cyc(3);
        reset = 1'b0;

        // Idle with an empty FIFO.
        cyc(10);
        check("idle_pops", pop_cnt, 0);
        check("idle_bytes", log_data.size(), 0);

        // Single word, LSB first.
        push(32'h44332211);
        cyc(8);
        check("single_pops", pop_cnt, 1);
        check("single_nbytes", log_data.size(), 4);
        w = {log_data[3], log_data[2], log_data[1], log_data[0]};
        check("single_bytes", w, 32'h44332211);

        // Eight preloaded words form two frames.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(32'hA0B0C0D0 + 32'(i * 32'h01010101));
        cyc(2);
        out_ready = 1'b1;
        cyc(40);
        check("frames_nbytes", log_data.size(), 32);
        check("frames_last15", log_last[15], 1);
        check("frames_last31", log_last[31], 1);
        nlast = 0;
        foreach (log_last[i]) nlast += int'(log_last[i]);
        check("frames_nlast", nlast, 2);
        check("frames_count", frame_count, 2);

        // Backpressure pattern 1,0,0,1,...
        log_data.delete();
        push(32'h87654321);
        push(32'h0FEDCBA9);
        for (int i = 0; i < 40; i++) begin
            out_ready = (i % 3 == 0);
            cyc(1);
        end
        out_ready = 1'b1;
        cyc(2);
        check("bp_nbytes", log_data.size(), 8);
        w = {log_data[3], log_data[2], log_data[1], log_data[0]};
        check("bp_word0", w, 32'h87654321);
        w = {log_data[7], log_data[6], log_data[5], log_data[4]};
        check("bp_word1", w, 32'h0FEDCBA9);

        // FIFO runs dry, next word arrives later.
        push(32'h13579BDF);
        cyc(7);
        check("dry_idle", busy, 0);
        push(32'h2468ACE0);
        cyc(8);

        // Reset in the middle of a word.
        push(32'hCAFEF00D);
        cyc(3);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        #3;
        check("rst_valid", out_valid, 0);
        check("rst_frames", frame_count, 0);
        log_data.delete();
        cyc(1);
        push(32'hDEADBEEF);
        cyc(6);
        check("rst_nbytes", log_data.size(), 4);
        check("rst_byte0", log_data[0], 32'hEF);

        // Randomised pushes and backpressure.
        for (int i = 0; i < 800; i++) begin
            out_ready = ($urandom_range(3) != 0);
            if (fq.size() < 16 && $urandom_range(2) == 0) push($urandom);
            cyc(1);
        end
        out_ready = 1'b1;
        cyc(80);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
